// File: rtl/ahbl_master_input_stage.sv
// AHB-Lite per-master input stage.
// Holds an ungranted address phase and stalls the master until the bus takes it.
// Presents the live or held address phase to the arbiter and mux, and forwards the
// bus response to the master only during that master's own data phase.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no transfer outstanding; master sees HREADY=1
// S_WAIT | address phase held in hold regs, master stalled until accept
// S_DATA | this master owns the bus data phase; response passed through
`timescale 1ns/1ps
module ahbl_master_input_stage #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [ADDR_WIDTH-1:0] M_HADDR,
   input  logic [1:0]            M_HTRANS,
   input  logic                  M_HWRITE,
   input  logic [2:0]            M_HSIZE,
   input  logic [2:0]            M_HBURST,
   input  logic [3:0]            M_HPROT,
   input  logic                  M_HMASTLOCK,
   output logic                  M_HREADY,
   output logic                  M_HRESP,
   output logic [DATA_WIDTH-1:0] M_HRDATA,
   output logic [ADDR_WIDTH-1:0] O_HADDR,
   output logic [1:0]            O_HTRANS,
   output logic                  O_HWRITE,
   output logic [2:0]            O_HSIZE,
   output logic [2:0]            O_HBURST,
   output logic [3:0]            O_HPROT,
   output logic                  O_HMASTLOCK,
   input  logic                  GRANT,
   input  logic                  HREADY,
   input  logic                  HRESP,
   input  logic [DATA_WIDTH-1:0] HRDATA
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    hold_valid_q, hold_valid_d;
   logic                    capture;
   logic [ADDR_WIDTH-1:0]   hold_addr_q;
   logic [1:0]              hold_trans_q;
   logic                    hold_write_q;
   logic [2:0]              hold_size_q;
   logic [2:0]              hold_burst_q;
   logic [3:0]              hold_prot_q;
   logic                    hold_lock_q;
   logic                    mready;
   logic                    live;
   logic                    accept;

   // Master-facing response is a pure function of the state.
   always_comb begin
      mready   = 1'b1;
      M_HRESP  = 1'b0;
      M_HRDATA = '0;
      case (state_q)
         S_WAIT: mready = 1'b0;
         S_DATA: begin
            mready   = HREADY;
            M_HRESP  = HRESP;
            M_HRDATA = HRDATA;
         end
         default: mready = 1'b1;
      endcase
   end

   assign M_HREADY = mready;
   assign live     = mready & M_HTRANS[1];
   // GRANT only selects which O_* the mux forwards, so accept needs no O_* term.
   assign accept   = GRANT & HREADY;

   // Next-state decode; capture fires only when a live transfer is not accepted.
   always_comb begin
      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      capture      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (live && accept) begin
               state_d = S_DATA;
            end else if (live) begin
               capture      = 1'b1;
               hold_valid_d = 1'b1;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            if (accept) begin
               hold_valid_d = 1'b0;
               state_d      = S_DATA;
            end
         end
         S_DATA: begin
            // With HREADY low the master is holding its next phase; nothing moves.
            if (HREADY) begin
               if (live && accept) begin
                  state_d = S_DATA;
               end else if (live) begin
                  capture      = 1'b1;
                  hold_valid_d = 1'b1;
                  state_d      = S_WAIT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d      = S_IDLE;
            hold_valid_d = 1'b0;
         end
      endcase
   end

   // State and hold-valid registers; reset drops any held transfer.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q      <= S_IDLE;
         hold_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   // Hold registers load only on capture and stay stable through WAIT.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold_addr_q  <= '0;
         hold_trans_q <= 2'b00;
         hold_write_q <= 1'b0;
         hold_size_q  <= 3'd0;
         hold_burst_q <= 3'd0;
         hold_prot_q  <= 4'd0;
         hold_lock_q  <= 1'b0;
      end else if (capture) begin
         hold_addr_q  <= M_HADDR;
         hold_trans_q <= M_HTRANS;
         hold_write_q <= M_HWRITE;
         hold_size_q  <= M_HSIZE;
         hold_burst_q <= M_HBURST;
         hold_prot_q  <= M_HPROT;
         hold_lock_q  <= M_HMASTLOCK;
      end
   end

   // Arbiter-facing phase: held copy when valid, else the live master signals.
   // Forced to zero in reset so the arbiter never sees a transfer from a master
   // that is still driving one while the bus is being reset.
   always_comb begin
      O_HADDR     = M_HADDR;
      O_HTRANS    = M_HTRANS;
      O_HWRITE    = M_HWRITE;
      O_HSIZE     = M_HSIZE;
      O_HBURST    = M_HBURST;
      O_HPROT     = M_HPROT;
      O_HMASTLOCK = M_HMASTLOCK;
      if (!HRESETn) begin
         O_HADDR     = '0;
         O_HTRANS    = 2'b00;
         O_HWRITE    = 1'b0;
         O_HSIZE     = 3'd0;
         O_HBURST    = 3'd0;
         O_HPROT     = 4'd0;
         O_HMASTLOCK = 1'b0;
      end else if (hold_valid_q) begin
         O_HADDR     = hold_addr_q;
         O_HTRANS    = hold_trans_q;
         O_HWRITE    = hold_write_q;
         O_HSIZE     = hold_size_q;
         O_HBURST    = hold_burst_q;
         O_HPROT     = hold_prot_q;
         O_HMASTLOCK = hold_lock_q;
      end
   end

endmodule
